instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC/next-PC register.
- Takes the current PC, runs one request/response transaction on the instruction-memory bus, and presents the returned word to the decoder.
- Uses a valid/ready handshake with the decoder.
- Drives PCwrt back to the PC register, so the PC advances only after the decoder accepts an instruction.
- Detects misaligned PCs and bus timeouts, and reports them as a sticky fault.

Parameters:
- TIMEOUT, 255: maximum clock cycles spent in REQ+WAIT for one transaction before a fault is declared; legal range 1..65535.
- ADDR_W, 32: PC and memory address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; clk is the single clock
- PC  input  ADDR_W  current PC from the PC register
- fetch_en  input  1  fetch enable, sampled only in IDLE
- mem_req  output  1  bus request
- mem_addr  output  ADDR_W  registered request address
- mem_gnt  input  1  bus accepted the request
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data
- instr  output  32  fetched instruction
- instr_valid  output  1  instr is valid for the decoder
- dec_ready  input  1  decoder accepts instr
- PCwrt  output  1  PC-advance strobe to the PC register
- fetch_err  output  1  sticky fault flag
- err_pc  output  ADDR_W  PC of the faulting fetch

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mem_req=0, mem_addr=0, instr=0, instr_valid=0, fetch_err=0, err_pc=0, timeout counter=0.
  - PCwrt=0 while reset=0.
  - A transaction in flight is dropped. Any later mem_rvalid is ignored because data is captured only in WAIT.
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE:
  - fetch_en=1 and PC[1:0]==0: mem_addr<=PC, mem_req<=1, counter<=0, go to REQ.
  - fetch_en=1 and PC[1:0]!=0: err_pc<=PC, fetch_err<=1, go to ERR.
  - fetch_en=0: stay in IDLE.
- REQ:
  - mem_req=1; mem_addr is held stable.
  - mem_gnt=1: mem_req<=0, go to WAIT.
  - mem_rvalid is ignored in REQ. The bus never returns data in the same cycle as the grant.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: instr<=mem_rdata, instr_valid<=1, go to HOLD.
- Timeout:
  - The counter increments every cycle spent in REQ or WAIT.
  - If the counter reaches TIMEOUT-1 without leaving the state: err_pc<=mem_addr, fetch_err<=1, mem_req<=0, go to ERR.
  - A grant or rvalid arriving in that same cycle takes priority over the timeout.
- HOLD:
  - instr_valid=1; instr is held stable while dec_ready=0.
  - PCwrt is combinational: PCwrt = (state==HOLD) && dec_ready. It is high in exactly the cycle the handshake completes.
  - On handshake: instr_valid<=0, go to IDLE.
  - The fetch unit returns to IDLE instead of REQ because the PC register updates on the same edge as the handshake. IDLE samples the new PC one cycle later.
- ERR:
  - Terminal. mem_req=0, instr_valid=0, PCwrt=0; fetch_err and err_pc are held.
  - ERR is left only through reset.
- fetch_en is sampled only in IDLE. Deasserting it mid-transaction does not cancel the transaction; the instruction still completes through HOLD.
- Throughput: with an immediate grant, rvalid one cycle later and dec_ready=1, one instruction is accepted every 4 cycles (IDLE, REQ, WAIT, HOLD).
- PCwrt never asserts outside HOLD. It never asserts twice for one fetched word.

Test Plan:
- Basic fetch: PC=0x00000010, fetch_en=1, mem_gnt in cycle 1, rvalid with rdata=0x20080005 in cycle 2, dec_ready=1 -> mem_addr=0x10; instr=0x20080005 with instr_valid=1 in cycle 3; PCwrt=1 only in cycle 3; state returns to IDLE in cycle 4.
- Decoder backpressure: as the basic fetch, but dec_ready=0 for 5 cycles, then 1 -> instr_valid and instr held stable for 5 cycles; PCwrt is 0 throughout, then a single 1-cycle pulse; no new mem_req meanwhile.
- Misaligned PC: PC=0x00000006, fetch_en=1 -> fetch_err=1 and err_pc=0x6 next cycle; mem_req never asserts; PCwrt stays 0 for 20 further cycles.
- Timeout: TIMEOUT=8, PC=0x40, mem_gnt held 0 -> mem_req high for 8 cycles, then ERR with fetch_err=1, err_pc=0x40 and mem_req=0.
- Reset mid-transaction: reset=0 while in WAIT, release, then pulse mem_rvalid with rdata=0xDEADBEEF -> instr stays 0, instr_valid=0, PCwrt=0; the next fetch with PC=0 proceeds normally.
- Back-to-back with a PC register model: fetch_en=1 constant, PC incremented by 4 on each PCwrt -> mem_addr sequence 0x0, 0x4, 0x8, 0xC; one PCwrt pulse per accepted word; 4 cycles per instruction.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundles for the fetch stage: instruction-memory request/response bus
// and the valid/ready handshake towards the decoder.

// Memory bus: the master holds mem_req and mem_addr until mem_gnt; read data
// returns later as a single mem_rvalid beat, never in the grant cycle.
interface instr_mem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// Decoder handshake: a word transfers on every cycle where instr_valid and
// dec_ready are both high; once raised, instr_valid and instr stay stable
// until that transfer happens.
interface instr_dec_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        dec_ready;

    modport master (
        output instr,
        output instr_valid,
        input  dec_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output dec_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one memory read for the current PC, hands the word to the
// decoder and strobes PCwrt on acceptance; misaligned PCs and timeouts are sticky.

module instr_fetch_unit #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_en,
    instr_mem_if.master       mem,
    instr_dec_if.master       dec,
    output logic              PCwrt,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] err_pc,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        timed_out;

    // >= rather than == so a grant taken on the last allowed cycle still
    // leaves WAIT bounded by the timeout.
    assign timed_out = (cnt >= CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            mem.mem_req     <= 1'b0;
            mem.mem_addr    <= '0;
            dec.instr       <= '0;
            dec.instr_valid <= 1'b0;
            fetch_err       <= 1'b0;
            err_pc          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        if (PC[1:0] == 2'b00) begin
                            mem.mem_addr <= PC;
                            mem.mem_req  <= 1'b1;
                            cnt          <= '0;
                            state        <= REQ;
                        end else begin
                            err_pc    <= PC;
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end
                    end
                end

                REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        cnt         <= cnt + 16'd1;
                        state       <= WAIT;
                    end else if (timed_out) begin
                        err_pc      <= mem.mem_addr;
                        fetch_err   <= 1'b1;
                        mem.mem_req <= 1'b0;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                WAIT: begin
                    if (mem.mem_rvalid) begin
                        dec.instr       <= mem.mem_rdata;
                        dec.instr_valid <= 1'b1;
                        state           <= HOLD;
                    end else if (timed_out) begin
                        err_pc    <= mem.mem_addr;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // Back to IDLE, not REQ: the PC register updates on this same
                // edge, so the next address is only visible a cycle later.
                HOLD: begin
                    if (dec.dec_ready) begin
                        dec.instr_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end

                ERR: begin
                    mem.mem_req     <= 1'b0;
                    dec.instr_valid <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign PCwrt     = reset && (state == HOLD) && dec.dec_ready;
    assign dbg_state = state;

endmodule
